// File: rtl/cla_carry_sum_seq.sv
// Sequential carry/sum stage for a 2-bit propagate/generate front end.
// Each accepted beat resolves one 2-bit group, least-significant first,
// and one carry register links the groups. After the last group, the
// sum, carry-out and signed overflow are offered on a valid/ready port.
module cla_carry_sum_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_p,
  input  logic [1:0]       in_g,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NGRP = WIDTH / 2;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CW-1:0] LAST_GRP = CW'(NGRP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             accept;
  logic             last_beat;
  logic             c, c1, c2;
  logic [WIDTH-1:0] sum_nxt;

  // The DONE state both qualifies the result and blocks new groups, so a
  // result is never overwritten while downstream is stalling.
  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  // The counter is 0 in IDLE, so one compare covers both IDLE and ACCUM.
  assign last_beat = (cnt == LAST_GRP);

  // Two-level carry lookahead for the current group and its sum bits.
  always_comb begin
    // NOTE: every signal driven here gets a default first; otherwise a
    // path that skips an assignment would infer a latch.
    c       = (state == IDLE) ? cin : carry;
    c1      = in_g[0] | (in_p[0] & c);
    c2      = in_g[1] | (in_p[1] & c1);
    sum_nxt = out_sum;
    for (int i = 0; i < NGRP; i++) begin
      if (cnt == CW'(i)) begin
        sum_nxt[2*i]   = in_p[0] ^ c;
        sum_nxt[2*i+1] = in_p[1] ^ c1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, whatever the order of statements.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: advance on beats, release DONE on the handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_beat ? DONE : ACCUM;
      ACCUM:   if (accept && last_beat) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: carry chain, group counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry    <= 1'b0;
      cnt      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      carry   <= c2;
      out_sum <= sum_nxt;
      if (last_beat) begin
        cnt      <= '0;
        out_cout <= c2;
        // c1 of the top group is the carry into bit WIDTH-1.
        out_ovf  <= c1 ^ c2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cla_carry_sum_seq.sv
// Directed bench for cla_carry_sum_seq (WIDTH=8). The bench splits operands
// into p/g groups and computes the expected results arithmetically into a
// scoreboard queue. The queue is popped when the DUT presents a result.
module tb_cla_carry_sum_seq;

  localparam int W = 8;
  localparam int NG = W / 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cin;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_p;
  logic [1:0]   in_g;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  cla_carry_sum_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_g      (in_g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition; overflow from carry into the MSB.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0]   full;
    logic [W-1:0] low;
    res_t         r;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    low    = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, ci};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = low[W-1] ^ full[W];
    return r;
  endfunction

  // Present one group and wait (bounded) until it is accepted.
  task automatic drive_beat(input logic [1:0] p, input logic [1:0] g, input logic ci);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_p     = p;
    in_g     = g;
    cin      = ci;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
        break;
      end
    end
    check("beat_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  // Send ngs groups of a+b; optional 2-cycle gap after group gap_after,
  // optional cin toggling on later beats, optional scoreboard push.
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input int ngs, input int gap_after, input bit toggle_cin,
                         input bit push);
    logic [W-1:0] p, g;
    logic         c;
    p = a ^ b;
    g = a & b;
    c = ci;
    if (push) sb.push_back(model(a, b, ci));
    for (int k = 0; k < ngs; k++) begin
      drive_beat(p[2*k +: 2], g[2*k +: 2], c);
      if (toggle_cin) c = ~c;
      if (k < NG - 1) check("no_early_valid", 32'(out_valid), 32'd0);
      if (k == gap_after) begin
        repeat (2) @(posedge clk);
        #1;
        check("gap_hold_valid", 32'(out_valid), 32'd0);
      end
    end
  endtask

  // Wait (bounded) for a result, compare with the scoreboard, handshake.
  task automatic collect(input string tag);
    bit   got;
    res_t e;
    got       = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_valid"}, 32'(got), 32'd1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sum"},  32'(out_sum),  32'(e.sum));
      check({tag, "_cout"}, 32'(out_cout), 32'(e.cout));
      check({tag, "_ovf"},  32'(out_ovf),  32'(e.ovf));
      @(posedge clk);
      #1;
      check({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
      check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cin       = 1'b0;
    in_valid  = 1'b0;
    in_p      = 2'b00;
    in_g      = 2'b00;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum",   32'(out_sum),   32'd0);
    check("rst_cout",  32'(out_cout),  32'd0);
    check("rst_ovf",   32'(out_ovf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);

    // Case 1: 0x5A + 0x3C, result one cycle after the last beat.
    send_op(8'h5A, 8'h3C, 1'b0, NG, -1, 1'b0, 1'b1);
    check("t1_latency", 32'(out_valid), 32'd1);
    collect("t1");

    // Case 2: 0xFF + 0x01, full carry ripple.
    send_op(8'hFF, 8'h01, 1'b0, NG, -1, 1'b0, 1'b1);
    collect("t2");

    // Case 3: carry-in only, then 0x80 + 0x80.
    send_op(8'h00, 8'h00, 1'b1, NG, -1, 1'b0, 1'b1);
    check("t3_done_ready", 32'(in_ready), 32'd0);
    collect("t3a");
    send_op(8'h80, 8'h80, 1'b0, NG, -1, 1'b0, 1'b1);
    collect("t3b");

    // Case 4: backpressure with a pending beat on the input.
    out_ready = 1'b0;
    send_op(8'h5A, 8'h3C, 1'b0, NG, -1, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_p     = 2'b10;
    in_g     = 2'b00;
    repeat (3) begin
      check("t4_ready", 32'(in_ready),  32'd0);
      check("t4_valid", 32'(out_valid), 32'd1);
      check("t4_sum",   32'(out_sum),   32'(sb[0].sum));
      check("t4_cout",  32'(out_cout),  32'(sb[0].cout));
      check("t4_ovf",   32'(out_ovf),   32'(sb[0].ovf));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    collect("t4");

    // Case 5: input gap between groups 1 and 2, cin toggled later.
    send_op(8'hFF, 8'h01, 1'b0, NG, 1, 1'b1, 1'b1);
    collect("t5");

    // Case 6: reset after two beats, then a fresh case 1.
    send_op(8'h5A, 8'h3C, 1'b0, 2, -1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_sum",   32'(out_sum),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_ready", 32'(in_ready),  32'd1);
    check("t6_valid", 32'(out_valid), 32'd0);
    send_op(8'h5A, 8'h3C, 1'b0, NG, -1, 1'b0, 1'b1);
    collect("t6");

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
